// File: rtl/clr_seq.sv
// rtl/clr_seq.sv - sequential one-bit-per-cycle rotator with IDLE/RUN/DONE control
//
// Purpose: rotates operand x by y bit positions, one position per clock,
//          and presents the result in r with a one-cycle done pulse.
// Optional feature macro: CLR_SEQ_DIR_EN
//   defined   -> dir selects the direction (0 left, 1 right)
//   undefined -> every rotation is left and dir is ignored
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   start - request a rotation (accepted in IDLE or DONE)
//   x     - operand, captured on the accepting edge
//   y     - rotate amount, captured on the accepting edge
//   dir   - rotate direction (used only with CLR_SEQ_DIR_EN)
//   r     - result register
//   busy  - high while rotating
//   done  - one-cycle pulse, r valid

module clr_seq #(
    parameter int WIDTH = 28,
    parameter int AMT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [AMT_W-1:0] y,
    input  logic             dir,
    output logic [WIDTH-1:0] r,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [AMT_W-1:0] cnt;
    logic             load;
    logic             step;
    logic             rot_dir;
    logic [WIDTH-1:0] rot_left;
    logic [WIDTH-1:0] rot_right;

    // The bit leaving one end re-enters at the other, so nothing is lost.
    assign rot_left  = {r[WIDTH-2:0], r[WIDTH-1]};
    assign rot_right = {r[0], r[WIDTH-1:1]};

`ifdef CLR_SEQ_DIR_EN
    logic dir_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_q <= 1'b0;
        end else if (load) begin
            dir_q <= dir;
        end
    end

    assign rot_dir = dir_q;
`else
    // Direction is fixed to left; dir is masked off rather than stored.
    assign rot_dir = dir & 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = (y == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                step = 1'b1;
                // Last step happens on the edge that takes cnt from 1 to 0.
                if (cnt <= AMT_W'(1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    load       = 1'b1;
                    state_next = (y == '0) ? DONE : RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r   <= '0;
            cnt <= '0;
        end else if (load) begin
            r   <= x;
            cnt <= y;
        end else if (step) begin
            r   <= rot_dir ? rot_right : rot_left;
            cnt <= cnt - AMT_W'(1);
        end
    end

endmodule

// File: tb/tb_clr_seq.sv
// tb/tb_clr_seq.sv - scoreboard bench for clr_seq

module tb_clr_seq;

    localparam int WIDTH = 28;
    localparam int AMT_W = 5;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] x;
    logic [AMT_W-1:0] y;
    logic             dir;
    logic [WIDTH-1:0] r;
    logic             busy;
    logic             done;

    typedef struct {
        logic [WIDTH-1:0] r;
        int               cyc;
        int               busy_n;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    int   busy_cnt = 0;

    clr_seq #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .x     (x),
        .y     (y),
        .dir   (dir),
        .r     (r),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: checks every done pulse against the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_cnt = 0;
        end else begin
            if (busy && done) begin
                n_vec++; n_fail++;
                $display("FAIL busy_and_done: busy=%b done=%b required not both high", busy, done);
            end
            if (busy) busy_cnt++;
            if (done) begin
                if (exp_q.size() == 0) begin
                    n_vec++; n_fail++;
                    $display("FAIL unexpected_done: cycle=%0d r=%h required no done", cyc, r);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    n_vec++;
                    if (r !== e.r) begin
                        n_fail++;
                        $display("FAIL result: r=%h required %h", r, e.r);
                    end
                    n_vec++;
                    if (cyc != e.cyc) begin
                        n_fail++;
                        $display("FAIL done_latency: done after edge %0d required edge %0d", cyc, e.cyc);
                    end
                    n_vec++;
                    if (busy_cnt != e.busy_n) begin
                        n_fail++;
                        $display("FAIL busy_cycles: busy %0d cycles required %0d", busy_cnt, e.busy_n);
                    end
                end
                busy_cnt = 0;
            end
        end
    end

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic push(input logic [WIDTH-1:0] er, input int k, input int yv);
        exp_t e;
        e.r = er; e.cyc = k + yv; e.busy_n = yv;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || done) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) begin
            n_vec++; n_fail++;
            $display("FAIL timeout: busy=%b done=%b still active after 100 cycles", busy, done);
        end
    endtask

    // Called at posedge+1; issues one op and waits for it to complete.
    task automatic op(input logic [WIDTH-1:0] xv, input int yv, input logic dv,
                      input logic [WIDTH-1:0] ev);
        x = xv; y = AMT_W'(yv); dir = dv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        push(ev, cyc, yv);
        wait_idle();
        check("hold_idle", r, ev);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; x = '0; y = '0; dir = 1'b0;
        #1;
        check("reset_r", r, '0);
        check("reset_busy", {27'd0, busy}, '0);
        check("reset_done", {27'd0, done}, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Left rotate: bits 27 and 0 move to 4 and 5.
        op(28'h8000001, 5, 1'b0, 28'h0000030);
        // Zero amount goes straight to DONE with r == x.
        op(28'h1234567, 0, 1'b0, 28'h1234567);
        // Full-width amount returns the operand.
        op(28'h8000001, 28, 1'b0, 28'h8000001);
        // y=31 matches y=3.
        op(28'h8000001, 31, 1'b0, 28'h000000C);
        op(28'h0000001, 27, 1'b0, 28'h8000000);
`ifdef CLR_SEQ_DIR_EN
        op(28'h8000001, 1, 1'b1, 28'hC000000);
        op(28'h0000010, 2, 1'b1, 28'h0000004);
`else
        op(28'h8000001, 1, 1'b1, 28'h0000003);
        op(28'h0000010, 2, 1'b1, 28'h0000040);
`endif

        // start during RUN is ignored.
        x = 28'h00000F0; y = 5'd4; dir = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        push(28'h0000F00, cyc, 4);
        @(posedge clk); #1;
        x = '0; y = 5'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle();
        check("ignore_result", r, 28'h0000F00);

        // Back-to-back: start held while in DONE.
        x = 28'h0000001; y = 5'd2; dir = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        push(28'h0000004, cyc, 2);
        begin
            int n = 0;
            while (!done && n < 50) begin
                @(posedge clk); #1;
                n++;
            end
            if (n >= 50) begin
                n_vec++; n_fail++;
                $display("FAIL b2b_timeout: done=%b never rose", done);
            end
        end
        x = 28'hA000000; y = 5'd1; dir = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        push(28'h4000001, cyc, 1);
        check("b2b_busy", {27'd0, busy}, 28'd1);
        check("b2b_done_once", {27'd0, done}, 28'd0);
        wait_idle();
        check("b2b_result", r, 28'h4000001);

        // Reset mid-RUN aborts the op; no done may follow.
        x = 28'h8000001; y = 5'd9; dir = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_r", r, '0);
        check("abort_busy", {27'd0, busy}, '0);
        check("abort_done", {27'd0, done}, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (12) begin @(posedge clk); #1; end
        // First op after reset release still works normally.
        op(28'h0000003, 1, 1'b0, 28'h0000006);

        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL pending_expect: %0d left required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/clr_seq.md
CLR_SEQ -- requirements
Module: clr_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 28, meaning data width in bits (WIDTH >= 2).
REQ-002 SHALL have parameter AMT_W, default 5, meaning rotate-amount width in bits.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  request a rotation, sampled on rising clk.
REQ-006 SHALL have port x  input  WIDTH  operand, captured when start is accepted.
REQ-007 SHALL have port y  input  AMT_W  unsigned rotate amount, captured with x.
REQ-008 SHALL have port dir  input  1  rotate direction: 0 left, 1 right (see REQ-027).
REQ-009 SHALL have port r  output  WIDTH  result register, driven directly from a flop.
REQ-010 SHALL have port busy  output  1  high while a rotation is in progress.
REQ-011 SHALL have port done  output  1  one-cycle pulse marking r as valid.

Function
REQ-012 SHALL implement the three-state FSM IDLE, RUN, DONE.
REQ-013 SHALL accept start only in IDLE or DONE; at accepting edge k, capture x into r, y into a down-counter and dir into a direction flop.
REQ-014 SHALL, on accepting start with y != 0, enter RUN; with y == 0, enter DONE directly, so r == x.
REQ-015 SHALL, in RUN, on each edge, rotate r by exactly one bit position in the captured direction and decrement the counter.
REQ-016 SHALL leave RUN for DONE on the edge where the counter goes from 1 to 0, so done is high in the cycle after edge k+y.
REQ-017 SHALL assert busy exactly while in RUN; busy and done SHALL never be high together.
REQ-018 SHALL assert done only in DONE, for exactly one cycle; DONE SHALL return to IDLE on the next edge unless start is high, which is then accepted (back-to-back operation).
REQ-019 SHALL ignore start, x, y and dir while in RUN; the operation in progress SHALL be unaffected.
REQ-020 SHALL hold r unchanged in IDLE and DONE until the next accepted start; r in RUN shows intermediate values and is not valid.
REQ-021 SHALL perform full y-step rotation for y >= WIDTH, so the result equals rotation by y mod WIDTH with latency y cycles; there is no modulo reduction.
REQ-022 SHALL compute the one-bit rotation so the vacated end receives the bit shifted out, with no loss for any WIDTH.

Reset
REQ-023 SHALL, while rst_n is low, force state IDLE, r = 0, counter = 0, direction = 0, busy = 0, done = 0, independently of clk.
REQ-024 SHALL abort any operation in progress on rst_n assertion mid-RUN; no done pulse SHALL follow.
REQ-025 SHALL treat the first rising clk edge after rst_n deasserts as a normal IDLE edge that may accept start.

Configuration
REQ-026 SHALL support macro CLR_SEQ_DIR_EN.
REQ-027 SHALL, with CLR_SEQ_DIR_EN defined, honour dir per REQ-008; without it, dir SHALL be ignored, every rotation SHALL be left, and no direction flop SHALL be built. The port SHALL be kept in both builds.

Verification
REQ-028 Reset: rst_n=0 mid-RUN with y=9 -> r=0, busy=0, done=0 immediately; no done pulse after release.
REQ-029 Left rotate: x=28'b1000000000000000000000000001, y=5, dir=0, start at edge k -> busy for 5 cycles, done after edge k+5, r=28'h0000030.
REQ-030 Zero and full amounts: y=0 -> done after edge k with r=x; y=28 -> done after edge k+28 with r=x; y=31 -> r equals the y=3 result.
REQ-031 Right rotate (CLR_SEQ_DIR_EN defined): x=28'b1000000000000000000000000001, y=1, dir=1 -> r=28'hC000000; same stimulus without the macro -> r=28'h0000003.
REQ-032 Busy-ignore: start a y=4 op, then pulse start with x=0, y=1 during RUN -> original result, done pulses exactly once.
REQ-033 Back-to-back: start held high during DONE -> new op accepted that edge, done high one cycle only, then busy next cycle.
